// File: rtl/vga_if.sv
// Video raster bundle between the timing generator and its consumers
// (pixel fetch stage and video pins).
interface vga_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;
    logic        running;

    modport master (
        output hsync, vsync, de, x, y, frame_start, running
    );

    modport slave (
        input hsync, vsync, de, x, y, frame_start, running
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator, gated by a PLL lock that must be
// stable for LOCK_WAIT cycles before the raster starts.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int LOCK_WAIT = 1024
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   lock,
    vga_if.master  vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int STAB_W   = $clog2(LOCK_WAIT) + 1;

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    logic              lock_meta_q;
    logic              lock_s_q;
    state_t            state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [10:0]       h_cnt_q, h_cnt_d;
    logic [10:0]       v_cnt_q, v_cnt_d;

    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q, de_d;
    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic              frame_start_q, frame_start_d;
    logic              running_q, running_d;

    // Lock comes straight from the PLL, unrelated to clk edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            stab_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        case (state_q)
            ST_WAIT: begin
                if (!lock_s_q) begin
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_W'(LOCK_WAIT - 1)) begin
                    state_d    = ST_RUN;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d    = ST_WAIT;
                    stab_cnt_d = '0;
                end else if (h_cnt_q == 11'(H_TOTAL - 1)) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt_q + 11'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 11'd1;
                    v_cnt_d = v_cnt_q;
                end
            end
            default: begin
                state_d    = ST_WAIT;
                stab_cnt_d = '0;
            end
        endcase
    end

    // Qualifying with lock_s_q idles the outputs on the same edge the FSM
    // leaves RUN, so a lock loss truncates sync pulses immediately.
    logic run_now;
    logic h_act, v_act;

    always_comb begin
        run_now       = (state_q == ST_RUN) && lock_s_q;
        h_act         = h_cnt_q < 11'(H_ACTIVE);
        v_act         = v_cnt_q < 11'(V_ACTIVE);
        de_d          = run_now && h_act && v_act;
        hsync_d       = !(run_now && (h_cnt_q >= 11'(HS_START)) && (h_cnt_q < 11'(HS_END)));
        vsync_d       = !(run_now && (v_cnt_q >= 11'(VS_START)) && (v_cnt_q < 11'(VS_END)));
        x_d           = de_d ? h_cnt_q : 11'd0;
        y_d           = de_d ? v_cnt_q : 11'd0;
        frame_start_d = run_now && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        running_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.frame_start = frame_start_q;
    assign vid.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x8 raster so that
// whole frames, lock glitches and resets fit in a short run.
module tb_vga_timing_gen;
    localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int LW = 16;
    localparam logic [26:0] RST_BUNDLE = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b0;

    vga_if vif();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LOCK_WAIT(LW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .lock (lock),
        .vid  (vif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          n;
        logic        de, hs, vs, fs, run;
        logic [10:0] x, y;
    } vec_t;

    vec_t tbl[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] bundle();
        return {vif.de, vif.hsync, vif.vsync, vif.frame_start, vif.running, vif.x, vif.y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Caller has lock=1 set before the next edge, which is edge 1.
    task automatic startup(input string tag);
        int early_de;
        early_de = 0;
        for (int k = 1; k <= LW + 3; k++) begin
            tick();
            if (k <= LW + 2 && vif.de) early_de++;
            if (k == LW + 1) check({tag, "_run_pre"}, 32'(vif.running), 32'd0);
            if (k == LW + 2) check({tag, "_run_on"}, 32'(vif.running), 32'd1);
            if (k == LW + 3) check({tag, "_first_px"}, 32'(bundle()),
                                   32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0}));
        end
        check({tag, "_no_early_de"}, 32'(early_de), 32'd0);
    endtask

    initial begin
        int cur, de_cnt, fs_cnt, budget, early_run;

        //          n    de hs vs fs run x  y
        tbl[0]  = '{0,   1, 1, 1, 1, 1,  0, 0};
        tbl[1]  = '{7,   1, 1, 1, 0, 1,  7, 0};
        tbl[2]  = '{8,   0, 1, 1, 0, 1,  0, 0};
        tbl[3]  = '{9,   0, 1, 1, 0, 1,  0, 0};
        tbl[4]  = '{10,  0, 0, 1, 0, 1,  0, 0};
        tbl[5]  = '{12,  0, 0, 1, 0, 1,  0, 0};
        tbl[6]  = '{13,  0, 1, 1, 0, 1,  0, 0};
        tbl[7]  = '{15,  1, 1, 1, 0, 1,  0, 1};
        tbl[8]  = '{47,  1, 1, 1, 0, 1,  2, 3};
        tbl[9]  = '{60,  0, 1, 1, 0, 1,  0, 0};
        tbl[10] = '{75,  0, 1, 0, 0, 1,  0, 0};
        tbl[11] = '{104, 0, 1, 0, 0, 1,  0, 0};
        tbl[12] = '{105, 0, 1, 1, 0, 1,  0, 0};
        tbl[13] = '{120, 1, 1, 1, 1, 1,  0, 0};
        tbl[14] = '{131, 0, 0, 1, 0, 1,  0, 0};

        // Reset state while clocks run.
        repeat (3) tick();
        check("reset_state", 32'(bundle()), 32'(RST_BUNDLE));
        rst  = 1'b0;
        lock = 1'b1;
        startup("startup");

        // Raster sweep; sample n is n cycles after the first frame_start.
        cur    = 0;
        de_cnt = 1;
        fs_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < tbl[i].n) begin
                tick();
                cur++;
                if (cur < 120) begin
                    if (vif.de) de_cnt++;
                    if (vif.frame_start) fs_cnt++;
                end
            end
            check($sformatf("vec%0d_n%0d", i, tbl[i].n), 32'(bundle()),
                  32'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].run, tbl[i].x, tbl[i].y}));
        end
        check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        check("fs_in_frame", 32'(fs_cnt), 32'd0);

        // Lock glitch in WAIT: lock_s low for one cycle around edge 14..15.
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        lock = 1'b1;
        early_run = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k == 12) lock = 1'b0;
            if (k == 13) lock = 1'b1;
            if (k < 30 && vif.running) early_run++;
            if (k == 30) check("glitch_run_pre", 32'(vif.running), 32'd0);
            if (k == 31) check("glitch_run_on", 32'(vif.running), 32'd1);
        end
        check("glitch_no_early_run", 32'(early_run), 32'd0);

        // Lock loss while hsync is low.
        budget = 0;
        while (vif.hsync !== 1'b0 && budget < 100) begin
            tick();
            budget++;
        end
        check("find_hsync_low", 32'(budget < 100), 32'd1);
        lock = 1'b0;
        tick();
        tick();
        check("loss_still_run", 32'({vif.running, vif.hsync}), 32'b10);
        tick();
        check("loss_idle", 32'({vif.hsync, vif.de, vif.running}), 32'b100);
        lock = 1'b1;
        startup("relock");

        // Asynchronous reset mid-frame.
        budget = 0;
        while (!(vif.de === 1'b1 && vif.y == 11'd2) && budget < 200) begin
            tick();
            budget++;
        end
        check("find_y2", 32'(budget < 200), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(bundle()), 32'(RST_BUNDLE));
        #1;
        rst = 1'b0;
        startup("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz video raster timing (hsync, vsync, data-enable, pixel coordinates) on the PLL pixel clock (27 MHz in, ~25.175 MHz out). It sits directly downstream of the pixel-clock PLL and consumes both its output clock and its `lock` flag. Raster generation is held off until `lock` has been stable for a programmable number of cycles, and restarts cleanly if lock is lost. Its outputs feed the pixel/framebuffer read stage and the video pins.

## Interface
Parameters:
- `H_ACTIVE`, default 640: active pixels per line
- `H_FP`, default 16: horizontal front porch (cycles)
- `H_SYNC`, default 96: hsync width (cycles)
- `H_BP`, default 48: horizontal back porch (cycles)
- `V_ACTIVE`, default 480: active lines per frame
- `V_FP`, default 10: vertical front porch (lines)
- `V_SYNC`, default 2: vsync width (lines)
- `V_BP`, default 33: vertical back porch (lines)
- `LOCK_WAIT`, default 1024: consecutive synchronized-lock-high cycles required before running (≥1)

Ports:
- `clk`, input, 1: pixel clock (PLL `clkout0`)
- `rst`, input, 1: reset, asynchronous, active-high
- `lock`, input, 1: PLL lock, treated as asynchronous
- `hsync`, output, 1: horizontal sync, active-low
- `vsync`, output, 1: vertical sync, active-low
- `de`, output, 1: data enable, high in active region
- `x`, output, 11: pixel column, valid when `de`=1
- `y`, output, 11: line number, valid when `de`=1
- `frame_start`, output, 1: 1-cycle pulse on first active pixel (0,0)
- `running`, output, 1: high while the FSM is in RUN

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high. All flops clear on `rst`.
- Lock synchronizer: `lock` passes through a 2-flop synchronizer to produce `lock_s`. Both flops reset to 0.
- FSM states:
  - WAIT: raster counters held at 0 and `stab_cnt` counts. If `lock_s`=0, `stab_cnt` clears to 0. If `lock_s`=1 and `stab_cnt`==LOCK_WAIT-1, go to RUN. Otherwise, if `lock_s`=1, `stab_cnt`+1.
  - RUN: if `lock_s`=0, go to WAIT, clearing `stab_cnt`, `h_cnt` and `v_cnt` to 0 on the same edge. Otherwise the raster counters advance.
- Raster counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters. On wrap it returns to 0 and `v_cnt` increments.
  - `v_cnt` runs 0..V_TOTAL-1 and wraps to 0 at end of frame.
- Region order per line: active [0,H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. Vertical order is the same.
- Registered outputs, updated from the current-cycle counters (one-cycle pipeline, all outputs aligned):
  - `de` = RUN && h<H_ACTIVE && v<V_ACTIVE
  - `hsync` = !(RUN && h in sync range)
  - `vsync` = !(RUN && v in sync range)
  - `x`=h and `y`=v when `de`, otherwise 0
  - `frame_start` = RUN && h==0 && v==0
  - `running` = RUN
- Reset values: `hsync`=1, `vsync`=1, `de`=0, `x`=0, `y`=0, `frame_start`=0, `running`=0. The FSM resets to WAIT.

## Timing
- Startup latency: `lock` is first sampled high at edge 1. Then `lock_s`=1 after edge 2, the FSM enters RUN at edge 2+LOCK_WAIT, and `frame_start`/`de`=1 with `x`=0, `y`=0 appear after edge 3+LOCK_WAIT.
- Steady state:
  - Line period is H_TOTAL cycles (800); frame period is H_TOTAL*V_TOTAL cycles (420000).
  - `frame_start` pulses exactly once per frame, each time for one cycle.
- Lock glitch in WAIT: any `lock_s`=0 cycle restarts the stability count from 0.
- Lock loss in RUN: the cycle after `lock_s` is seen low, outputs go idle (`de`=0, syncs=1, `running`=0). This can happen mid-line or mid-sync pulse; the sync pulse is truncated. On relock the raster resumes from (0,0) after the full LOCK_WAIT again.
- `rst` mid-frame: all outputs return immediately (asynchronously) to their reset values.

## Test plan
- Startup: LOCK_WAIT=16, `lock` raised and held → `running` high after edge 18; first `frame_start` plus `de`=1, `x`=0, `y`=0 after edge 19; no `de` earlier.
- Line timing with default parameters:
  - `de` high for 640 cycles and `x` runs 0..639.
  - `hsync` falls 16 cycles after `de` falls and stays low 96 cycles.
  - Consecutive `de` rising edges are 800 cycles apart.
- Frame timing:
  - 480 `de` lines per frame.
  - `vsync` low for exactly 1600 cycles, starting at h=0 of v=490 (registered).
  - `frame_start` interval is 420000 cycles.
- Lock glitch: LOCK_WAIT=16, `lock` dropped for 1 cycle after 10 stable cycles → RUN entry is delayed to 16 full cycles after `lock_s` returns high.
- Lock loss mid-sync: `lock` dropped while `hsync`=0 at x-count 700 → 3 cycles later `hsync`=1, `de`=0, `running`=0. After relock, the raster restarts at (0,0) with `frame_start`.
- Async reset mid-frame: `rst` asserted at v=200 → outputs go to their reset values without a clock edge. After release with `lock` high, startup follows the same 3+LOCK_WAIT latency.
